// File: rtl/data_bus_if.sv
// Wishbone classic master for the MEM stage data port.
// One access at a time; the pipeline is stalled while the bus is busy.
module data_bus_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cnt_q;
  logic [31:0] rd_buf_q;
  logic        cyc_q;
  logic        start;
  logic        done;
  logic        tmo;
  logic        fin;

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    fin        = 1'b0;
    stallreq_o = 1'b0;
    bus_err_o  = 1'b0;
    cpu_data_o = '0;
    unique case (state_q)
      IDLE: begin
        start      = cpu_ce_i & ~flush_i;
        stallreq_o = start;
        if (start) state_d = BUSY;
      end
      BUSY: begin
        // flush beats ack, ack beats timeout
        if (flush_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (wb_ack_i) begin
          fin        = 1'b1;
          done       = 1'b1;
          cpu_data_o = wb_dat_i;
          state_d    = stall_i ? HOLD : IDLE;
        end else if (cnt_q == 32'(TIMEOUT)) begin
          fin       = 1'b1;
          tmo       = 1'b1;
          bus_err_o = 1'b1;
          state_d   = stall_i ? HOLD : IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      HOLD: begin
        cpu_data_o = rd_buf_q;
        if (!stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stallreq_o = 1'b0;
      bus_err_o  = 1'b0;
      cpu_data_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_buf_q <= '0;
      cyc_q    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_sel_o <= cpu_sel_i;
        wb_we_o  <= cpu_we_i;
        cyc_q    <= 1'b1;
        cnt_q    <= '0;
      end else if (state_q == BUSY) begin
        if (fin) cyc_q <= 1'b0;
        else cnt_q <= cnt_q + 32'd1;
        if (done) rd_buf_q <= wb_dat_i;
        if (tmo) rd_buf_q <= '0;
      end
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed and randomized bench for data_bus_if.
// Expectations come from per-transaction records (waits, hold, data).
module tb_data_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic        stallreq_o, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  int checks = 0;
  int failures = 0;

  data_bus_if #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_sel_i(cpu_sel_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cpu();
    cpu_we_i   = 1'($urandom);
    cpu_addr_i = $urandom;
    cpu_sel_i  = 4'($urandom);
    cpu_data_i = $urandom;
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a;
    cpu_sel_i = s; cpu_data_i = d;
    stall_i = 1'b0; flush_i = 1'b0; wb_ack_i = 1'b0;
    @(negedge clk);
    chk("req_stallreq", 32'(stallreq_o), 1);
    chk("req_cyc_low", 32'(wb_cyc_o), 0);
    chk("req_cpu_data", cpu_data_o, 0);
    step();
    cpu_ce_i = 1'b0;
    scramble_cpu();
  endtask

  task automatic do_access(input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           input int waits, input logic [31:0] rdat,
                           input int hold);
    issue(we, a, s, d);
    for (int i = 0; i < waits; i++) begin
      wb_dat_i = $urandom;
      @(negedge clk);
      chk("wait_cyc", 32'(wb_cyc_o), 1);
      chk("wait_stb", 32'(wb_stb_o), 1);
      chk("wait_adr", wb_adr_o, a);
      chk("wait_dat", wb_dat_o, d);
      chk("wait_sel", 32'(wb_sel_o), 32'(s));
      chk("wait_we", 32'(wb_we_o), 32'(we));
      chk("wait_stallreq", 32'(stallreq_o), 1);
      chk("wait_cpu_data", cpu_data_o, 0);
      chk("wait_err", 32'(bus_err_o), 0);
      step();
    end
    wb_ack_i = 1'b1; wb_dat_i = rdat; stall_i = (hold > 0);
    @(negedge clk);
    chk("ack_stb", 32'(wb_stb_o), 1);
    chk("ack_adr", wb_adr_o, a);
    chk("ack_cpu_data", cpu_data_o, rdat);
    chk("ack_stallreq", 32'(stallreq_o), 0);
    chk("ack_err", 32'(bus_err_o), 0);
    step();
    wb_ack_i = 1'b0; wb_dat_i = $urandom;
    for (int h = 0; h < hold; h++) begin
      stall_i = (h < hold - 1);
      @(negedge clk);
      chk("hold_cpu_data", cpu_data_o, rdat);
      chk("hold_stallreq", 32'(stallreq_o), 0);
      chk("hold_cyc", 32'(wb_cyc_o), 0);
      step();
    end
    stall_i = 1'b0;
    wb_ack_i = 1'($urandom);
    @(negedge clk);
    chk("idle_cyc", 32'(wb_cyc_o), 0);
    chk("idle_cpu_data", cpu_data_o, 0);
    chk("idle_stallreq", 32'(stallreq_o), 0);
    chk("idle_err", 32'(bus_err_o), 0);
    step();
    wb_ack_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    scramble_cpu();
    @(negedge clk);
    chk("rst_cpu_data", cpu_data_o, 0);
    chk("rst_stallreq", 32'(stallreq_o), 0);
    step();
    step();
    rst = 1'b0; wb_ack_i = 1'b0;
    @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_err", 32'(bus_err_o), 0);
    step();

    do_access(1'b0, 32'h100, 4'hF, 32'h0, 0, 32'hDEADBEEF, 0);
    do_access(1'b1, 32'h200, 4'b0011, 32'h0000ABCD, 3, 32'h0, 0);
    do_access(1'b0, 32'h300, 4'hF, 32'h0, 1, 32'h12345678, 2);

    for (int k = 0; k < 20; k++)
      do_access(1'($urandom), $urandom, 4'($urandom), $urandom,
                int'($urandom_range(0, 5)), $urandom,
                int'($urandom_range(0, 3)));

    // ack on the very cycle the counter expires: completes normally
    do_access(1'b0, 32'h400, 4'hF, 32'h0, 255, 32'hCAFEF00D, 0);

    // flush on 2nd BUSY cycle, with ack that cycle and a late ack after
    issue(1'b0, 32'h500, 4'hF, 32'h0);
    @(negedge clk);
    chk("fl_busy_cyc", 32'(wb_cyc_o), 1);
    step();
    flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk);
    chk("fl_stallreq", 32'(stallreq_o), 0);
    chk("fl_cpu_data", cpu_data_o, 0);
    chk("fl_err", 32'(bus_err_o), 0);
    step();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_cyc", 32'(wb_cyc_o), 0);
    chk("fl_stb", 32'(wb_stb_o), 0);
    chk("fl_late_data", cpu_data_o, 0);
    chk("fl_late_stallreq", 32'(stallreq_o), 0);
    step();
    wb_ack_i = 1'b0;
    step();

    // timeout with no ack
    issue(1'b1, 32'h600, 4'hF, 32'h1);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (bus_err_o) break;
      step();
    end
    chk("tmo_cycle", n, 256);
    chk("tmo_stallreq", 32'(stallreq_o), 0);
    chk("tmo_cpu_data", cpu_data_o, 0);
    step();
    @(negedge clk);
    chk("tmo_cyc", 32'(wb_cyc_o), 0);
    chk("tmo_err_once", 32'(bus_err_o), 0);
    step();

    // reset mid-BUSY
    a = $urandom | 32'h1;
    issue(1'b1, a, 4'hF, 32'hFFFF_0001);
    @(negedge clk);
    chk("rb_cyc", 32'(wb_cyc_o), 1);
    step();
    rst = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
    @(negedge clk);
    chk("rb_stallreq", 32'(stallreq_o), 0);
    chk("rb_err", 32'(bus_err_o), 0);
    chk("rb_cpu_data", cpu_data_o, 0);
    step();
    rst = 1'b0; wb_ack_i = 1'b0;
    @(negedge clk);
    chk("rb_cyc_low", 32'(wb_cyc_o), 0);
    chk("rb_stb_low", 32'(wb_stb_o), 0);
    chk("rb_we", 32'(wb_we_o), 0);
    chk("rb_adr", wb_adr_o, 0);
    chk("rb_dat", wb_dat_o, 0);
    chk("rb_sel", 32'(wb_sel_o), 0);
    step();
    do_access(1'b0, 32'h700, 4'h3, 32'h0, 2, 32'h0BAD_C0DE, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_if.md
DATA_BUS_IF -- requirements
Module: data_bus_if

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port stall_i, input, 1 bit: the stage after MEM is held by pipeline control this cycle.
REQ-004 SHALL have port flush_i, input, 1 bit: pipeline flush (exception); the current access is cancelled.
REQ-005 SHALL have ports cpu_ce_i, input, 1 bit, and cpu_we_i, input, 1 bit: request valid and write enable, both from the MEM stage.
REQ-006 SHALL have ports cpu_addr_i, input, 32 bits; cpu_sel_i, input, 4 bits; cpu_data_i, input, 32 bits: byte address, byte lanes, and store data.
REQ-007 SHALL have port cpu_data_o, output, 32 bits: read data returned to the MEM stage.
REQ-008 SHALL have port stallreq_o, output, 1 bit: asks pipeline control to freeze while an access is pending.
REQ-009 SHALL have port bus_err_o, output, 1 bit: one-cycle pulse on bus timeout.
REQ-010 SHALL have Wishbone classic master outputs wb_adr_o (32), wb_dat_o (32), wb_sel_o (4), wb_we_o (1), wb_stb_o (1) and wb_cyc_o (1).
REQ-011 SHALL have Wishbone inputs wb_dat_i (32) and wb_ack_i (1).
REQ-012 SHALL have parameter TIMEOUT, default 255: the number of BUSY cycles without ack before the access aborts.

Function
REQ-013 SHALL implement states IDLE, BUSY and HOLD in a registered FSM.
REQ-014 IDLE with cpu_ce_i=1 and flush_i=0 SHALL, at the next edge, do all of the following:
- register adr/dat/sel/we from the cpu inputs;
- set wb_cyc_o=wb_stb_o=1;
- clear the timeout counter;
- enter BUSY.
REQ-015 IDLE SHALL drive stallreq_o = cpu_ce_i & ~flush_i combinationally and cpu_data_o=0.
REQ-016 BUSY without ack SHALL hold all wb outputs stable, assert stallreq_o=1, drive cpu_data_o=0, and increment the timeout counter.
REQ-017 BUSY with wb_ack_i=1 SHALL do all of the following:
- in the same cycle, drive cpu_data_o=wb_dat_i and stallreq_o=0;
- at the edge, latch wb_dat_i into rd_buf and clear cyc/stb;
- enter HOLD if stall_i=1, else IDLE.
REQ-018 HOLD SHALL drive cpu_data_o=rd_buf and stallreq_o=0, keep cyc/stb low, and return to IDLE at the first edge with stall_i=0.
REQ-019 BUSY with flush_i=1 SHALL, at the next edge, clear cyc/stb, discard any ack that arrives the same cycle, and enter IDLE; stallreq_o SHALL be 0 in that cycle.
REQ-020 When the counter reaches TIMEOUT without ack in BUSY, the block SHALL do all of the following:
- pulse bus_err_o=1 for that cycle;
- drive stallreq_o=0 and cpu_data_o=0;
- clear cyc/stb and set rd_buf=0;
- enter HOLD if stall_i=1, else IDLE.
REQ-021 Ack in the same cycle as the timeout condition SHALL win: a normal completion, with no bus_err_o.
REQ-022 wb_ack_i outside BUSY SHALL be ignored.
REQ-023 A new request SHALL never be issued from BUSY or HOLD; back-to-back requests need one IDLE cycle between them.
REQ-024 Latency SHALL be 1 cycle from request to stb, plus the slave wait states, with data available to the CPU in the ack cycle.
REQ-025 cpu_sel_i and cpu_data_i SHALL pass to the bus unmodified; the block performs no lane alignment.

Reset
REQ-026 With rst=1 at an edge, state SHALL become IDLE, the counter and rd_buf 0, and every registered wb output 0.
REQ-027 While rst=1, stallreq_o, bus_err_o and cpu_data_o SHALL be 0.
REQ-028 Reset during BUSY SHALL drop wb_cyc_o/wb_stb_o at that edge, with no error pulse.

Verification
REQ-029 Load, zero-wait slave: ce=1, we=0, addr=0x100, ack one cycle after stb with dat=0xDEADBEEF -> stb for exactly 1 cycle; cpu_data_o=0xDEADBEEF and stallreq_o=0 in the ack cycle.
REQ-030 Store, 3 wait states: we=1, sel=4'b0011, data=0x0000ABCD -> wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x0000ABCD stable for 4 cycles; stallreq_o=1 until the ack cycle.
REQ-031 Load completing with stall_i=1 for 2 cycles after ack, dat=0x12345678 -> HOLD for 2 cycles with cpu_data_o=0x12345678, then IDLE.
REQ-032 flush_i=1 on the 2nd BUSY cycle -> cyc/stb low next edge; a late ack is ignored; cpu_data_o=0.
REQ-033 No ack, TIMEOUT=255 -> bus_err_o pulses once after 255 BUSY cycles, cyc drops, stallreq_o goes 0.
REQ-034 rst=1 mid-BUSY -> all outputs 0 after the edge; a subsequent request restarts cleanly.
